// File: rtl/sram_pkg.sv
// Shared constants and types for the dual-port byte-enable SRAM and its clear engine.
package sram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_IDLE  = 2'd2
    } clr_state_t;

    function automatic int num_be(input int data_width, input int byte_width);
        return (data_width + byte_width - 1) / byte_width;
    endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// Clear engine: sweeps zeros through every word of the array after reset or on a clr pulse.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_INIT  | one settling cycle after reset release, then sweep
//   ST_CLEAR | writing zero to addr, addr increments each cycle
//   ST_IDLE  | array available to user traffic, waits for clr
module sram_clear_fsm
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int RAM_SIZE   = 36,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(RAM_SIZE - 1);
    localparam clr_state_t            RESET_STATE = INIT_CLEAR ? ST_INIT : ST_IDLE;

    clr_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RESET_STATE;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        clr_we    = 1'b0;
        case (state)
            ST_INIT: begin
                state_nxt = ST_CLEAR;
                addr_nxt  = '0;
            end
            ST_CLEAR: begin
                clr_we = 1'b1;
                // Stop on the last real word so the counter never runs past the array.
                if (addr == LAST_ADDR) begin
                    state_nxt = ST_IDLE;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = addr + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_nxt = ST_CLEAR;
                    addr_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                addr_nxt  = '0;
            end
        endcase
    end

    assign busy     = (state != ST_IDLE);
    assign clr_addr = addr;

endmodule

// File: rtl/sram_dp_be.sv
// Simple dual-port SRAM with byte-lane write enables, selectable read-during-write
// behaviour, 1/2-cycle read pipeline and a built-in zeroing sweep.
module sram_dp_be
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int ADDR_WIDTH   = 6,
    parameter int RAM_SIZE     = 36,
    parameter int BYTE_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 1,
    parameter bit INIT_CLEAR   = 1'b1,
    localparam int NUM_BE      = num_be(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  we,
    input  logic [NUM_BE-1:0]     wbe,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_SIZE - 1);

    logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  user_we, user_re;
    logic                  waddr_ok, raddr_ok;
    logic [DATA_WIDTH-1:0] bit_mask;
    logic [DATA_WIDTH-1:0] wr_old, wr_word;
    logic [DATA_WIDTH-1:0] rd_old, rd_word;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;

    sram_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_SIZE   (RAM_SIZE),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_clear (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign user_we  = we && !busy;
    assign user_re  = re && !busy;
    assign waddr_ok = (waddr <= LAST_ADDR);
    assign raddr_ok = (raddr <= LAST_ADDR);

    // Lanes past DATA_WIDTH in the top byte simply have no bits to map onto.
    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_mask
        assign bit_mask[b] = wbe[b / BYTE_WIDTH];
    end

    assign wr_old  = waddr_ok ? mem[waddr] : '0;
    assign wr_word = (wr_old & ~bit_mask) | (wdata & bit_mask);
    assign rd_old  = raddr_ok ? mem[raddr] : '0;

    always_comb begin
        rd_word = rd_old;
        if (RDW_MODE == RDW_NEW && user_we && raddr_ok && waddr == raddr) begin
            rd_word = wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (user_we && waddr_ok) begin
            mem[waddr] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= user_re;
            if (user_re) begin
                s1_data <= rd_word;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data;
        logic                  s2_valid;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s2_data  <= '0;
                s2_valid <= 1'b0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign rdata  = s2_data;
        assign rvalid = s2_valid;
    end else begin : g_lat1
        assign rdata  = s1_data;
        assign rvalid = s1_valid;
    end

endmodule

// File: doc/sram_dp_be.md
Name: sram_dp_be

Overview:
- Parametrised simple-dual-port SRAM: one write port and one read port, both on the same clock.
- Successor to the team's single-port 24x36 SRAM. Adds:
  - byte-write enables,
  - selectable read-during-write mode,
  - 1- or 2-cycle read latency with a valid flag,
  - a built-in clear engine that zeroes the array after reset or on request.
- Used as line/coefficient buffer storage in the lab datapaths.

Parameters:
- DATA_WIDTH, 24, word width in bits.
- ADDR_WIDTH, 6, address width.
- RAM_SIZE, 36, number of words; must satisfy RAM_SIZE <= 2**ADDR_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane. NUM_BE = ceil(DATA_WIDTH/BYTE_WIDTH). The top lane may be narrower.
- READ_LATENCY, 1, either 1 or 2 cycles from re to rdata/rvalid.
- RDW_MODE, 1, same-address read-during-write: 0 returns the old word, 1 returns the new (byte-merged) word.
- INIT_CLEAR, 1, 1 runs the clear sweep automatically after reset release.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- clr  in  1  one-cycle pulse that starts a clear sweep.
- busy  out  1  high while the clear sweep runs.
- we  in  1  write request.
- wbe  in  NUM_BE  byte-lane write enables; bit i covers data bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- waddr  in  ADDR_WIDTH  write address.
- wdata  in  DATA_WIDTH  write data.
- re  in  1  read request.
- raddr  in  ADDR_WIDTH  read address.
- rdata  out  DATA_WIDTH  read data.
- rvalid  out  1  rdata is valid this cycle.

Behaviour:
- Reset (reset_n low, asynchronous):
  - rdata=0, rvalid=0, pipeline stage registers=0.
  - Clear-FSM state = INIT if INIT_CLEAR=1, else IDLE; clear address=0.
  - busy=INIT_CLEAR.
  - Memory array is not reset.
- Clear FSM states: INIT, CLEAR, IDLE.
  - INIT: one cycle after reset release, then go to CLEAR with address 0.
  - CLEAR: write 0 to the clear address each cycle and increment it. After writing RAM_SIZE-1, go to IDLE. The sweep takes exactly RAM_SIZE cycles.
  - IDLE: clr=1 goes to CLEAR with address 0, no INIT cycle.
  - busy=1 in INIT and CLEAR.
  - clr is ignored while busy.
  - Reset asserted mid-sweep aborts it; the sweep restarts from address 0 after release (INIT_CLEAR=1), otherwise the FSM sits in IDLE.
- While busy:
  - we and re are ignored; no user write occurs.
  - No new rvalid is launched.
  - Reads already in the 2-stage pipeline still complete.
- Write, when not busy and we=1:
  - For each i with wbe[i]=1, the lane in RAM[waddr] takes the wdata lane.
  - Other lanes are unchanged.
  - wbe=0 with we=1 is a no-op.
  - waddr >= RAM_SIZE drops the write silently.
- Read, when not busy and re=1:
  - READ_LATENCY=1: rdata and rvalid are updated at the next posedge.
  - READ_LATENCY=2: a second register stage is added.
  - rvalid is high exactly one cycle per accepted re. Back-to-back reads give one valid per cycle.
  - With no read, rdata holds its last value and rvalid=0.
  - raddr >= RAM_SIZE returns 0 with rvalid=1.
- Same-cycle we & re with waddr==raddr:
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the pre-write word with enabled lanes replaced by wdata.
  - Different addresses: fully independent.
- Widths:
  - NUM_BE*BYTE_WIDTH may exceed DATA_WIDTH; excess bits of the top lane are discarded.
  - The clear address counter is ADDR_WIDTH bits and never wraps past RAM_SIZE-1.

Decomposition:
- Package sram_pkg holds:
  - RDW_OLD=0 and RDW_NEW=1,
  - clear-FSM state encoding ST_INIT/ST_CLEAR/ST_IDLE,
  - function num_be(DATA_WIDTH, BYTE_WIDTH).
- Sub-module sram_clear_fsm holds:
  - the FSM, address counter and busy,
  - outputs clr_we and clr_addr.
- The top muxes clear writes ahead of user writes and contains the array, byte-merge, bypass and read pipeline.

Test Plan:
- Reset, INIT_CLEAR=1: release reset_n → busy=1 for 1+36 cycles then 0. A read of every address 0..35 returns 0x000000 with rvalid one cycle after re.
- Byte enables:
  - Write 0xAABBCC at addr 5 with wbe=3'b111.
  - Then write 0x112233 with wbe=3'b010.
  - Read addr 5 → 0xAA22CC.
- Read-during-write: RAM[7]=0x000001, then same-cycle we(wbe=111, 0x123456)+re at addr 7:
  - RDW_MODE=0 → 0x000001.
  - RDW_MODE=1 → 0x123456.
  - Next read of addr 7 → 0x123456 in both modes.
- READ_LATENCY=2: reads of addr 1,2,3 on consecutive cycles → rvalid high on cycles +2,+3,+4 with the matching data. Out-of-range raddr=40 → 0x000000 with rvalid=1.
- clr mid-traffic:
  - Pulse clr with memory non-zero → busy for 36 cycles.
  - we/re asserted during busy have no effect (rvalid stays 0).
  - Memory reads back all zeros afterwards.
  - A second clr during busy does not extend it.
- Reset mid-sweep: assert reset_n low at sweep cycle 10 → rdata/rvalid=0 immediately. After release, busy holds for a full 1+36 cycles starting from address 0.
